i2c_slave_regfile: RTL and testbench



---
 rtl/i2c_slave_regfile.sv | 193 +++++++++++++++++++
 tb/tb_i2c_slave_regfile.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_slave_regfile.sv
// I2C register-file slave with synchronised bus decode, a 1/2-byte register pointer,
// auto-increment bursts, an out-of-range ID byte and a local write-strobe/readback port.
module i2c_slave_regfile #(
  parameter logic [6:0] SLAVE_ADDR  = 7'h77,
  parameter logic [7:0] DEV_ID      = 8'h52,
  parameter int         ADDR_BYTES  = 1,
  parameter int         DEPTH       = 32,
  parameter int         AUTO_INC    = 1,
  parameter int         SYNC_STAGES = 2,
  parameter logic [7:0] REG_INIT    = 8'h00,
  localparam int        PTR_W       = 8 * ADDR_BYTES
) (
  input  logic             clk_25,
  input  logic             reset_n,
  input  logic             scl_in,
  input  logic             sda_in,
  output logic             sda_out,
  output logic             wr_stb,
  output logic [PTR_W-1:0] wr_addr,
  output logic [7:0]       wr_data,
  input  logic [PTR_W-1:0] rd_addr,
  output logic [7:0]       rd_data,
  output logic             busy
);

  localparam int               IDX_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PTR_W:0]   DEPTH_C = (PTR_W + 1)'(DEPTH);
  localparam logic [PTR_W-1:0] LAST_C  = PTR_W'(DEPTH - 1);

  typedef enum logic [3:0] {
    IDLE, DEV_ADDR, DEV_ACK, PTR, PTR_ACK, WR_DATA, WR_ACK, RD_DATA, RD_ACK, WAIT_STOP
  } state_t;

  state_t                 state, state_nxt;
  logic [SYNC_STAGES-1:0] scl_sync_p0, sda_sync_p0;
  logic                   scl_p1, sda_p1;
  logic                   scl_s, sda_s, scl_rise, scl_fall, start_c, stop_c;
  logic [7:0]             shift, tx_sr, ptr_byte;
  logic [3:0]             cnt;
  logic                   byte_idx, mack;
  logic [PTR_W-1:0]       ptr, ptr_full, ptr_next;
  logic [7:0]             regs [DEPTH];
  logic                   byte_done, addr_match, ptr_in_range, last_ptr_byte, receiving;
  logic                   sda_nxt, do_write, ld_ptr, inc_ptr, ld_tx, shift_tx;

  // Synchroniser stages (p0) then edge-detect flop (p1)
  always_ff @(posedge clk_25 or negedge reset_n) begin
    if (!reset_n) begin
      scl_sync_p0 <= '1;
      sda_sync_p0 <= '1;
      scl_p1      <= 1'b1;
      sda_p1      <= 1'b1;
    end else begin
      scl_sync_p0 <= {scl_sync_p0[SYNC_STAGES-2:0], scl_in};
      sda_sync_p0 <= {sda_sync_p0[SYNC_STAGES-2:0], sda_in};
      scl_p1      <= scl_s;
      sda_p1      <= sda_s;
    end
  end

  assign scl_s    = scl_sync_p0[SYNC_STAGES-1];
  assign sda_s    = sda_sync_p0[SYNC_STAGES-1];
  assign scl_rise = scl_s & ~scl_p1;
  assign scl_fall = ~scl_s & scl_p1;
  assign start_c  = scl_s & scl_p1 & sda_p1 & ~sda_s;
  assign stop_c   = scl_s & scl_p1 & ~sda_p1 & sda_s;

  assign receiving     = (state == DEV_ADDR) || (state == PTR) || (state == WR_DATA);
  assign byte_done     = scl_fall && (cnt == 4'd8);
  assign addr_match    = (shift[7:1] == SLAVE_ADDR);
  assign ptr_in_range  = ({1'b0, ptr} < DEPTH_C);
  assign last_ptr_byte = (byte_idx == 1'(ADDR_BYTES - 1));
  assign ptr_next      = (ptr == LAST_C) ? '0 : ptr + PTR_W'(1);
  assign ptr_byte      = ptr_in_range ? regs[ptr[IDX_W-1:0]] : DEV_ID;
  assign rd_data       = ({1'b0, rd_addr} < DEPTH_C) ? regs[rd_addr[IDX_W-1:0]] : DEV_ID;
  assign busy          = (state != IDLE);

  // Earlier pointer bytes are held aside so an aborted pointer phase leaves the pointer intact
  if (ADDR_BYTES > 1) begin : g_ptr2
    logic [7:0] ptr_hi;
    always_ff @(posedge clk_25 or negedge reset_n) begin
      if (!reset_n)                       ptr_hi <= '0;
      else if (state == PTR && byte_done) ptr_hi <= shift;
    end
    assign ptr_full = {ptr_hi, shift};
  end else begin : g_ptr1
    assign ptr_full = shift;
  end

  always_ff @(posedge clk_25 or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (start_c)     state_nxt = DEV_ADDR;
    else if (stop_c) state_nxt = IDLE;
    else begin
      case (state)
        DEV_ADDR: if (byte_done) state_nxt = addr_match ? DEV_ACK : WAIT_STOP;
        DEV_ACK:  if (scl_fall)  state_nxt = shift[0] ? RD_DATA : PTR;
        PTR:      if (byte_done) state_nxt = PTR_ACK;
        PTR_ACK:  if (scl_fall)  state_nxt = last_ptr_byte ? WR_DATA : PTR;
        WR_DATA:  if (byte_done) state_nxt = ptr_in_range ? WR_ACK : WAIT_STOP;
        WR_ACK:   if (scl_fall)  state_nxt = WR_DATA;
        RD_DATA:  if (byte_done) state_nxt = RD_ACK;
        RD_ACK:   if (scl_fall)  state_nxt = mack ? WAIT_STOP : RD_DATA;
        default:                 state_nxt = state;
      endcase
    end
  end

  // SDA only moves on synced SCL falls; START/STOP always release it
  always_comb begin
    sda_nxt  = sda_out;
    do_write = 1'b0;
    ld_ptr   = 1'b0;
    inc_ptr  = 1'b0;
    ld_tx    = 1'b0;
    shift_tx = 1'b0;
    if (start_c || stop_c) sda_nxt = 1'b1;
    else begin
      case (state)
        DEV_ADDR: if (byte_done && addr_match) sda_nxt = 1'b0;
        DEV_ACK: if (scl_fall) begin
          sda_nxt = shift[0] ? ptr_byte[7] : 1'b1;
          ld_tx   = shift[0];
        end
        PTR: if (byte_done) begin
          sda_nxt = 1'b0;
          ld_ptr  = last_ptr_byte;
        end
        PTR_ACK, WR_ACK: if (scl_fall) sda_nxt = 1'b1;
        WR_DATA: if (byte_done && ptr_in_range) begin
          sda_nxt  = 1'b0;
          do_write = 1'b1;
          inc_ptr  = (AUTO_INC != 0);
        end
        RD_DATA: if (scl_fall) begin
          if (cnt == 4'd8) sda_nxt = 1'b1;
          else if (cnt != 4'd0) begin
            sda_nxt  = tx_sr[7];
            shift_tx = 1'b1;
          end
        end
        RD_ACK: begin
          inc_ptr = scl_rise && (AUTO_INC != 0);
          if (scl_fall && !mack) begin
            sda_nxt = ptr_byte[7];
            ld_tx   = 1'b1;
          end
        end
        default: sda_nxt = 1'b1;
      endcase
    end
  end

  always_ff @(posedge clk_25 or negedge reset_n) begin
    if (!reset_n) begin
      sda_out  <= 1'b1;
      wr_stb   <= 1'b0;
      wr_addr  <= '0;
      wr_data  <= '0;
      shift    <= '0;
      tx_sr    <= '1;
      cnt      <= '0;
      byte_idx <= 1'b0;
      mack     <= 1'b1;
      ptr      <= '0;
      for (int i = 0; i < DEPTH; i++) regs[i] <= REG_INIT;
    end else begin
      sda_out <= sda_nxt;
      wr_stb  <= do_write;
      if (start_c || state_nxt != state)           cnt <= '0;
      else if (scl_rise && (receiving || state == RD_DATA)) cnt <= cnt + 4'd1;
      if (scl_rise && receiving)                   shift <= {shift[6:0], sda_s};
      if (state == DEV_ACK)                        byte_idx <= 1'b0;
      else if (state == PTR_ACK && scl_fall)       byte_idx <= 1'b1;
      if (state == RD_ACK && scl_rise)             mack <= sda_s;
      if (ld_ptr)                                  ptr <= ptr_full;
      else if (inc_ptr)                            ptr <= ptr_next;
      if (ld_tx)                                   tx_sr <= {ptr_byte[6:0], 1'b1};
      else if (shift_tx)                           tx_sr <= {tx_sr[6:0], 1'b1};
      if (do_write) begin
        regs[ptr[IDX_W-1:0]] <= shift;
        wr_addr              <= ptr;
        wr_data              <= shift;
      end
    end
  end

endmodule

// File: tb/tb_i2c_slave_regfile.sv
// Directed bench: an I2C master model drives two slaves on one wired-AND bus
// (default 1-byte/32-reg slave and a 2-byte/300-reg/no-increment slave).
module tb_i2c_slave_regfile;

  logic        clk_25 = 1'b0;
  logic        reset_n;
  logic        scl_m = 1'b1, sda_m = 1'b1;
  logic        sda_bus;
  logic        sda_out_a, wr_stb_a, busy_a;
  logic [7:0]  wr_addr_a, wr_data_a, rd_addr_a, rd_data_a;
  logic        sda_out_b, wr_stb_b, busy_b;
  logic [15:0] wr_addr_b, rd_addr_b;
  logic [7:0]  wr_data_b, rd_data_b;

  always #20 clk_25 = ~clk_25;
  assign sda_bus = sda_m & sda_out_a & sda_out_b;

  i2c_slave_regfile dut_a (
    .clk_25(clk_25), .reset_n(reset_n), .scl_in(scl_m), .sda_in(sda_bus),
    .sda_out(sda_out_a), .wr_stb(wr_stb_a), .wr_addr(wr_addr_a), .wr_data(wr_data_a),
    .rd_addr(rd_addr_a), .rd_data(rd_data_a), .busy(busy_a)
  );

  i2c_slave_regfile #(
    .SLAVE_ADDR(7'h3C), .DEV_ID(8'h99), .ADDR_BYTES(2), .DEPTH(300),
    .AUTO_INC(0), .SYNC_STAGES(3), .REG_INIT(8'hC3)
  ) dut_b (
    .clk_25(clk_25), .reset_n(reset_n), .scl_in(scl_m), .sda_in(sda_bus),
    .sda_out(sda_out_b), .wr_stb(wr_stb_b), .wr_addr(wr_addr_b), .wr_data(wr_data_b),
    .rd_addr(rd_addr_b), .rd_data(rd_data_b), .busy(busy_b)
  );

  logic [7:0]  qa_addr [$];
  logic [7:0]  qa_data [$];
  logic [15:0] qb_addr [$];
  logic [7:0]  qb_data [$];
  int          low_a = 0;
  int          n_cmp = 0;
  int          n_fail = 0;

  always @(negedge clk_25) begin
    if (wr_stb_a) begin
      qa_addr.push_back(wr_addr_a);
      qa_data.push_back(wr_data_a);
    end
    if (wr_stb_b) begin
      qb_addr.push_back(wr_addr_b);
      qb_data.push_back(wr_data_b);
    end
    if (!sda_out_a) low_a = low_a + 1;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  task automatic clks(input int n);
    repeat (n) @(negedge clk_25);
  endtask

  task automatic bus_start();
    sda_m = 1'b1; clks(6); scl_m = 1'b1; clks(12);
    sda_m = 1'b0; clks(12); scl_m = 1'b0; clks(6);
  endtask

  task automatic bus_stop();
    sda_m = 1'b0; clks(6); scl_m = 1'b1; clks(12);
    sda_m = 1'b1; clks(12);
  endtask

  task automatic put_bit(input logic b);
    sda_m = b; clks(6); scl_m = 1'b1; clks(12); scl_m = 1'b0; clks(6);
  endtask

  task automatic get_bit(output logic b);
    sda_m = 1'b1; clks(6); scl_m = 1'b1; clks(6);
    b = sda_bus; clks(6); scl_m = 1'b0; clks(6);
  endtask

  task automatic put_chk(input logic [7:0] d, input logic exp_ack, input string name);
    logic a;
    for (int i = 7; i >= 0; i--) put_bit(d[i]);
    get_bit(a);
    check(name, 32'(a), 32'(exp_ack));
  endtask

  task automatic get_byte(input logic ack, output logic [7:0] d);
    logic b;
    for (int i = 7; i >= 0; i--) begin
      get_bit(b);
      d[i] = b;
    end
    put_bit(ack);
  endtask

  task automatic write_a(input logic [7:0] p, input logic [7:0] d, input logic exp_ack);
    bus_start();
    put_chk(8'hEE, 1'b0, "wr_dev_ack");
    put_chk(p, 1'b0, "wr_ptr_ack");
    put_chk(d, exp_ack, "wr_data_ack");
    bus_stop();
  endtask

  task automatic read_a(input logic [7:0] p, output logic [7:0] d);
    bus_start();
    put_chk(8'hEE, 1'b0, "rd_dev_ack");
    put_chk(p, 1'b0, "rd_ptr_ack");
    bus_start();
    put_chk(8'hEF, 1'b0, "rd_devr_ack");
    get_byte(1'b1, d);
    bus_stop();
  endtask

  typedef struct {
    logic [7:0] ptr;
    logic [7:0] data;
    logic       exp_ack;
    logic [7:0] exp_rd;
  } vec_t;

  initial begin
    vec_t       vecs [5];
    logic [7:0] d;
    int         base_a, base_b, base_low;

    vecs[0] = '{8'h05, 8'hA5, 1'b0, 8'hA5};
    vecs[1] = '{8'h1E, 8'h3C, 1'b0, 8'h3C};
    vecs[2] = '{8'h20, 8'h11, 1'b1, 8'h52};
    vecs[3] = '{8'hFF, 8'h00, 1'b1, 8'h52};
    vecs[4] = '{8'h10, 8'hFF, 1'b0, 8'hFF};

    reset_n = 1'b0; rd_addr_a = 8'h05; rd_addr_b = 16'd299;
    clks(4); reset_n = 1'b1; clks(2);
    check("rst_sda_out", 32'(sda_out_a), 32'h1);
    check("rst_busy", 32'(busy_a), 32'h0);
    check("rst_wr_stb", 32'(wr_stb_a), 32'h0);
    check("rst_wr_addr", 32'(wr_addr_a), 32'h0);
    check("rst_wr_data", 32'(wr_data_a), 32'h0);
    check("rst_reg5", 32'(rd_data_a), 32'h00);
    check("rst_b_reg299", 32'(rd_data_b), 32'hC3);
    rd_addr_a = 8'h20; rd_addr_b = 16'd300; clks(1);
    check("rst_a_devid", 32'(rd_data_a), 32'h52);
    check("rst_b_devid", 32'(rd_data_b), 32'h99);

    // Write burst with auto-increment
    base_a = qa_addr.size();
    bus_start();
    check("burst_busy", 32'(busy_a), 32'h1);
    put_chk(8'hEE, 1'b0, "burst_dev_ack");
    put_chk(8'h00, 1'b0, "burst_ptr_ack");
    put_chk(8'h11, 1'b0, "burst_d0_ack");
    put_chk(8'h22, 1'b0, "burst_d1_ack");
    put_chk(8'h33, 1'b0, "burst_d2_ack");
    bus_stop();
    check("burst_busy_end", 32'(busy_a), 32'h0);
    check("burst_stb_cnt", 32'(qa_addr.size() - base_a), 32'd3);
    if (qa_addr.size() - base_a == 3) begin
      check("burst_stb0", {qa_addr[base_a], qa_data[base_a]}, 32'h0011);
      check("burst_stb1", {qa_addr[base_a+1], qa_data[base_a+1]}, 32'h0122);
      check("burst_stb2", {qa_addr[base_a+2], qa_data[base_a+2]}, 32'h0233);
    end
    rd_addr_a = 8'h01; clks(1);
    check("burst_rb1", 32'(rd_data_a), 32'h22);

    // Combined write-pointer / repeated-START read of two bytes
    base_a = qa_addr.size();
    bus_start();
    put_chk(8'hEE, 1'b0, "comb_dev_ack");
    put_chk(8'h01, 1'b0, "comb_ptr_ack");
    bus_start();
    put_chk(8'hEF, 1'b0, "comb_devr_ack");
    get_byte(1'b0, d);
    check("comb_rd0", 32'(d), 32'h22);
    get_byte(1'b1, d);
    check("comb_rd1", 32'(d), 32'h33);
    bus_stop();
    check("comb_sda_rel", 32'(sda_out_a), 32'h1);
    check("comb_no_stb", 32'(qa_addr.size() - base_a), 32'd0);

    // Address mismatch
    base_a = qa_addr.size(); base_low = low_a;
    bus_start();
    put_chk(8'hA0, 1'b1, "mis_dev_nack");
    check("mis_busy", 32'(busy_a), 32'h1);
    put_chk(8'h05, 1'b1, "mis_byte_nack");
    bus_stop();
    check("mis_sda_low", 32'(low_a - base_low), 32'd0);
    check("mis_no_stb", 32'(qa_addr.size() - base_a), 32'd0);
    check("mis_busy_end", 32'(busy_a), 32'h0);

    // Pointer wrap at DEPTH-1 and out-of-range handling
    base_a = qa_addr.size();
    bus_start();
    put_chk(8'hEE, 1'b0, "wrap_dev_ack");
    put_chk(8'h1F, 1'b0, "wrap_ptr_ack");
    put_chk(8'hAA, 1'b0, "wrap_d0_ack");
    put_chk(8'hBB, 1'b0, "wrap_d1_ack");
    bus_stop();
    check("wrap_stb_cnt", 32'(qa_addr.size() - base_a), 32'd2);
    if (qa_addr.size() - base_a == 2)
      check("wrap_stb1", {qa_addr[base_a+1], qa_data[base_a+1]}, 32'h00BB);
    rd_addr_a = 8'h1F; clks(1);
    check("wrap_reg31", 32'(rd_data_a), 32'hAA);
    rd_addr_a = 8'h00; clks(1);
    check("wrap_reg0", 32'(rd_data_a), 32'hBB);
    base_a = qa_addr.size();
    write_a(8'h40, 8'h77, 1'b1);
    check("oor_no_stb", 32'(qa_addr.size() - base_a), 32'd0);
    read_a(8'h40, d);
    check("oor_rd_devid", 32'(d), 32'h52);

    // Single-byte write/readback vectors
    for (int i = 0; i < 5; i++) begin
      base_a = qa_addr.size();
      write_a(vecs[i].ptr, vecs[i].data, vecs[i].exp_ack);
      check("vec_stb_cnt", 32'(qa_addr.size() - base_a), vecs[i].exp_ack ? 32'd0 : 32'd1);
      rd_addr_a = vecs[i].ptr; clks(1);
      check("vec_rd_port", 32'(rd_data_a), 32'(vecs[i].exp_rd));
      read_a(vecs[i].ptr, d);
      check("vec_rd_bus", 32'(d), 32'(vecs[i].exp_rd));
    end

    // Two-byte pointer, no auto-increment
    base_a = qa_addr.size(); base_b = qb_addr.size();
    bus_start();
    put_chk(8'h78, 1'b0, "b_dev_ack");
    put_chk(8'h01, 1'b0, "b_ptr_hi_ack");
    put_chk(8'h2B, 1'b0, "b_ptr_lo_ack");
    put_chk(8'h5A, 1'b0, "b_d0_ack");
    put_chk(8'h6B, 1'b0, "b_d1_ack");
    bus_stop();
    check("b_stb_cnt", 32'(qb_addr.size() - base_b), 32'd2);
    if (qb_addr.size() - base_b == 2) begin
      check("b_stb0", {qb_addr[base_b], qb_data[base_b]}, 32'h012B5A);
      check("b_stb1", {qb_addr[base_b+1], qb_data[base_b+1]}, 32'h012B6B);
    end
    check("b_a_quiet", 32'(qa_addr.size() - base_a), 32'd0);
    rd_addr_b = 16'd299; clks(1);
    check("b_reg299", 32'(rd_data_b), 32'h6B);

    // Reset while the slave is driving a 0 data bit
    bus_start();
    put_chk(8'hEE, 1'b0, "rstrd_dev_ack");
    put_chk(8'h01, 1'b0, "rstrd_ptr_ack");
    bus_start();
    put_chk(8'hEF, 1'b0, "rstrd_devr_ack");
    check("rstrd_drive_low", 32'(sda_out_a), 32'h0);
    rd_addr_a = 8'h01;
    #5 reset_n = 1'b0;
    #1;
    check("rstrd_sda_rel", 32'(sda_out_a), 32'h1);
    check("rstrd_busy", 32'(busy_a), 32'h0);
    check("rstrd_reg1", 32'(rd_data_a), 32'h00);
    check("rstrd_b_reg299", 32'(rd_data_b), 32'hC3);
    clks(3); reset_n = 1'b1;
    scl_m = 1'b1; sda_m = 1'b1; clks(20);
    check("rstrd_idle_busy", 32'(busy_a), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
